// File: rtl/load_exec_unit_pkg.sv
// Shared definitions for the load execution unit: reservation-station tags,
// FSM state encoding and datapath width.
package load_exec_unit_pkg;

    localparam int XLEN  = 64;
    localparam int TAG_W = 4;

    typedef logic [TAG_W-1:0] tag_t;

    localparam tag_t TAG_NOTAG  = 4'd0;
    localparam tag_t TAG_ADD_1  = 4'd1;
    localparam tag_t TAG_ADD_2  = 4'd2;
    localparam tag_t TAG_ADD_3  = 4'd3;
    localparam tag_t TAG_MULT_1 = 4'd4;
    localparam tag_t TAG_MULT_2 = 4'd5;
    localparam tag_t TAG_LD_1   = 4'd6;
    localparam tag_t TAG_LD_2   = 4'd7;
    localparam tag_t TAG_LD_3   = 4'd8;
    localparam tag_t TAG_ST_1   = 4'd9;
    localparam tag_t TAG_ST_2   = 4'd10;

    typedef enum logic [2:0] {
        IDLE,
        AGEN,
        MEM_REQ,
        MEM_WAIT,
        CDB,
        FREE
    } le_state_t;

    // Round-robin pointer advance over the three station slots.
    function automatic logic [1:0] rr_next(input logic [1:0] slot);
        return (slot >= 2'd2) ? 2'd0 : slot + 2'd1;
    endfunction

endpackage

// File: rtl/load_exec_unit_if.sv
// Station query, memory, CDB and free-request signals of the load execution unit.
// The master modport is the unit itself; slave is the surrounding station/memory/CDB.
interface load_exec_unit_if #(
    parameter int XLEN = load_exec_unit_pkg::XLEN
);
    import load_exec_unit_pkg::*;

    logic [2:0]      ready_bus;
    logic            ld_aff_ready;
    logic [XLEN-1:0] ld_affinity_op;
    logic [XLEN-1:0] ld_affinity_offset;
    tag_t            query_tag;
    logic [XLEN-1:0] address;

    logic            mem_req_valid;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_req_ready;
    logic            mem_resp_valid;
    logic [XLEN-1:0] mem_resp_data;

    logic            cdb_req;
    logic            cdb_grant;
    tag_t            cdb_id_out;
    logic [XLEN-1:0] cdb_data_out;

    logic            free_tag_flag;
    tag_t            free_this_tag;
    logic            busy;

    modport master (
        input  ready_bus, ld_aff_ready, ld_affinity_op, ld_affinity_offset,
        input  mem_req_ready, mem_resp_valid, mem_resp_data, cdb_grant,
        output query_tag, address, mem_req_valid, mem_req_addr,
        output cdb_req, cdb_id_out, cdb_data_out,
        output free_tag_flag, free_this_tag, busy
    );

    modport slave (
        output ready_bus, ld_aff_ready, ld_affinity_op, ld_affinity_offset,
        output mem_req_ready, mem_resp_valid, mem_resp_data, cdb_grant,
        input  query_tag, address, mem_req_valid, mem_req_addr,
        input  cdb_req, cdb_id_out, cdb_data_out,
        input  free_tag_flag, free_this_tag, busy
    );

endinterface

// File: rtl/load_exec_unit_ld_rr_picker.sv
// Three-way round-robin selector: first ready slot at or after rr_ptr, wrapping.
// ready and grant are slot-indexed (bit 0 = slot 0).
module ld_rr_picker (
    input  logic [2:0] ready,
    input  logic [1:0] rr_ptr,
    output logic [2:0] grant,
    output logic       valid
);

    function automatic logic [1:0] wrap3(input logic [2:0] v);
        return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
    endfunction

    logic [1:0] cand;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = 0; k < 3; k++) begin
            cand = wrap3({1'b0, rr_ptr} + 3'(k));
            if (!valid && ready[cand]) begin
                grant[cand] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/load_exec_unit.sv
// Load execution unit: picks a ready load from the 3-entry station, computes its
// effective address, reads memory, broadcasts on the CDB and frees the entry.
//
// state    | meaning
// IDLE     | waiting for a ready slot; round-robin pick, query issued
// AGEN     | station answers the query; effective address formed or load dropped
// MEM_REQ  | read request held until memory accepts
// MEM_WAIT | waiting for read data
// CDB      | broadcast held until the arbiter grants
// FREE     | one-cycle free pulse back to the station
module load_exec_unit
    import load_exec_unit_pkg::*;
#(
    parameter int XLEN        = load_exec_unit_pkg::XLEN,
    parameter int LD_TAG_BASE = 6
) (
    input  logic              clk,
    input  logic              rst,
    load_exec_unit_if.master  bus
);

    le_state_t       state_q, state_d;
    logic [1:0]      rr_ptr_q, rr_ptr_d;
    tag_t            tag_q, tag_d;
    logic [XLEN-1:0] eff_q, eff_d;

    tag_t            query_tag_q, query_tag_d;
    logic [XLEN-1:0] address_q, address_d;
    logic            mem_valid_q, mem_valid_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic            cdb_req_q, cdb_req_d;
    tag_t            cdb_id_q, cdb_id_d;
    logic [XLEN-1:0] cdb_data_q, cdb_data_d;
    logic            free_flag_q, free_flag_d;
    tag_t            free_tag_q, free_tag_d;

    logic [2:0]      slot_ready;
    logic [2:0]      pick_grant;
    logic            pick_valid;
    logic [1:0]      pick_slot;
    logic [XLEN-1:0] eff_sum;

    // ready_bus is MSB-first by slot; the picker wants bit n = slot n.
    assign slot_ready = {bus.ready_bus[0], bus.ready_bus[1], bus.ready_bus[2]};
    assign eff_sum    = bus.ld_affinity_op + bus.ld_affinity_offset;

    ld_rr_picker u_picker (
        .ready  (slot_ready),
        .rr_ptr (rr_ptr_q),
        .grant  (pick_grant),
        .valid  (pick_valid)
    );

    always_comb begin
        pick_slot = 2'd0;
        if (pick_grant[1]) pick_slot = 2'd1;
        else if (pick_grant[2]) pick_slot = 2'd2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            tag_q       <= TAG_NOTAG;
            eff_q       <= '0;
            query_tag_q <= TAG_NOTAG;
            address_q   <= '0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            cdb_req_q   <= 1'b0;
            cdb_id_q    <= TAG_NOTAG;
            cdb_data_q  <= '0;
            free_flag_q <= 1'b0;
            free_tag_q  <= TAG_NOTAG;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            tag_q       <= tag_d;
            eff_q       <= eff_d;
            query_tag_q <= query_tag_d;
            address_q   <= address_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            cdb_req_q   <= cdb_req_d;
            cdb_id_q    <= cdb_id_d;
            cdb_data_q  <= cdb_data_d;
            free_flag_q <= free_flag_d;
            free_tag_q  <= free_tag_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        tag_d       = tag_q;
        eff_d       = eff_q;
        query_tag_d = query_tag_q;
        address_d   = address_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        cdb_req_d   = cdb_req_q;
        cdb_id_d    = cdb_id_q;
        cdb_data_d  = cdb_data_q;
        free_flag_d = free_flag_q;
        free_tag_d  = free_tag_q;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    tag_d       = tag_t'(LD_TAG_BASE) + tag_t'(pick_slot);
                    query_tag_d = tag_t'(LD_TAG_BASE) + tag_t'(pick_slot);
                    rr_ptr_d    = rr_next(pick_slot);
                    state_d     = AGEN;
                end
            end
            AGEN: begin
                query_tag_d = TAG_NOTAG;
                if (bus.ld_aff_ready) begin
                    eff_d       = eff_sum;
                    address_d   = eff_sum;
                    mem_valid_d = 1'b1;
                    mem_addr_d  = eff_sum;
                    state_d     = MEM_REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            MEM_REQ: begin
                mem_addr_d = eff_q;
                if (bus.mem_req_ready) begin
                    mem_valid_d = 1'b0;
                    state_d     = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (bus.mem_resp_valid) begin
                    cdb_req_d  = 1'b1;
                    cdb_id_d   = tag_q;
                    cdb_data_d = bus.mem_resp_data;
                    state_d    = CDB;
                end
            end
            CDB: begin
                if (bus.cdb_grant) begin
                    cdb_req_d   = 1'b0;
                    cdb_id_d    = TAG_NOTAG;
                    free_flag_d = 1'b1;
                    free_tag_d  = tag_q;
                    state_d     = FREE;
                end
            end
            FREE: begin
                free_flag_d = 1'b0;
                free_tag_d  = TAG_NOTAG;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.query_tag     = query_tag_q;
    assign bus.address       = address_q;
    assign bus.mem_req_valid = mem_valid_q;
    assign bus.mem_req_addr  = mem_addr_q;
    assign bus.cdb_req       = cdb_req_q;
    assign bus.cdb_id_out    = cdb_id_q;
    assign bus.cdb_data_out  = cdb_data_q;
    assign bus.free_tag_flag = free_flag_q;
    assign bus.free_this_tag = free_tag_q;
    assign bus.busy          = (state_q != IDLE);

endmodule

// File: tb/tb_load_exec_unit.sv
// Directed bench for load_exec_unit: station, memory and CDB responders around the
// DUT, with a scoreboard of expected {tag, address, data} per load.
module tb_load_exec_unit;
    import load_exec_unit_pkg::*;

    typedef struct {
        logic [3:0]  tag;
        logic [63:0] addr;
        logic [63:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    load_exec_unit_if bus ();

    load_exec_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];

    int          st_arm  [3];
    int          st_done [3];
    int          st_drop [3];
    logic [63:0] st_op   [3];
    logic [63:0] st_off  [3];
    logic        aff_force_low;
    logic [2:0]  slot_rdy;
    int          qidx;

    int          req_stall, resp_lat, grant_stall;
    logic        ovr_en;
    logic [63:0] ovr_data;
    int          done_cnt = 0;
    int          free_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mem_value(input logic [63:0] a);
        return ovr_en ? ovr_data : (a ^ 64'hC3C3_0000_5A5A_0000);
    endfunction

    task automatic push(input logic [3:0] t, input logic [63:0] a);
        exp_t e;
        e.tag  = t;
        e.addr = a;
        e.data = mem_value(a);
        sb.push_back(e);
    endtask

    // Station model: a slot is ready while it has armed loads not yet freed or dropped.
    always_comb begin
        for (int s = 0; s < 3; s++) slot_rdy[s] = (st_arm[s] > st_done[s] + st_drop[s]);
    end
    assign bus.ready_bus = {slot_rdy[0], slot_rdy[1], slot_rdy[2]};

    always_comb begin
        qidx                   = 0;
        bus.ld_aff_ready       = 1'b0;
        bus.ld_affinity_op     = '0;
        bus.ld_affinity_offset = '0;
        if (bus.query_tag >= 4'd6 && bus.query_tag <= 4'd8) begin
            qidx                   = int'(bus.query_tag) - 6;
            bus.ld_aff_ready       = slot_rdy[qidx] && !aff_force_low;
            bus.ld_affinity_op     = st_op[qidx];
            bus.ld_affinity_offset = st_off[qidx];
        end
    end

    always @(negedge clk) if (bus.free_tag_flag) free_cnt++;

    initial begin : mem_proc
        logic [63:0] a0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_req_valid && !rst) begin
                a0 = bus.mem_req_addr;
                if (sb.size() > 0) begin
                    chk("mem_req_addr", a0, sb[0].addr);
                    chk("address_out", bus.address, sb[0].addr);
                end else chk("sb_empty_at_mem", sb.size(), 1);
                chk("query_clear_in_req", bus.query_tag, 0);
                repeat (req_stall) begin
                    @(negedge clk);
                    chk("req_addr_hold", bus.mem_req_addr, a0);
                    chk("req_valid_hold", bus.mem_req_valid, 1);
                end
                bus.mem_req_ready = 1'b1;
                @(negedge clk);
                bus.mem_req_ready = 1'b0;
                chk("req_valid_drop", bus.mem_req_valid, 0);
                repeat (resp_lat) @(negedge clk);
                bus.mem_resp_valid = 1'b1;
                bus.mem_resp_data  = mem_value(a0);
                @(negedge clk);
                bus.mem_resp_valid = 1'b0;
                bus.mem_resp_data  = '0;
            end
        end
    end

    initial begin : cdb_proc
        exp_t        e;
        logic [3:0]  id0;
        logic [63:0] d0;
        bus.cdb_grant = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.cdb_req && !rst) begin
                id0 = bus.cdb_id_out;
                d0  = bus.cdb_data_out;
                repeat (grant_stall) begin
                    @(negedge clk);
                    chk("cdb_req_hold", bus.cdb_req, 1);
                    chk("cdb_id_hold", bus.cdb_id_out, id0);
                    chk("cdb_data_hold", bus.cdb_data_out, d0);
                end
                bus.cdb_grant = 1'b1;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("cdb_id", id0, e.tag);
                    chk("cdb_data", d0, e.data);
                end else chk("sb_empty_at_cdb", sb.size(), 1);
                @(negedge clk);
                bus.cdb_grant = 1'b0;
                chk("free_flag", bus.free_tag_flag, 1);
                chk("free_tag", bus.free_this_tag, id0);
                chk("cdb_req_drop", bus.cdb_req, 0);
                chk("cdb_id_zero", bus.cdb_id_out, 0);
                if (bus.free_this_tag >= 4'd6 && bus.free_this_tag <= 4'd8)
                    st_done[int'(bus.free_this_tag) - 6]++;
                done_cnt++;
                @(negedge clk);
                chk("free_pulse_end", bus.free_tag_flag, 0);
                chk("free_tag_zero", bus.free_this_tag, 0);
            end
        end
    end

    task automatic check_zero(input string p);
        chk({p, "_query_tag"}, bus.query_tag, 0);
        chk({p, "_address"}, bus.address, 0);
        chk({p, "_mem_req_valid"}, bus.mem_req_valid, 0);
        chk({p, "_mem_req_addr"}, bus.mem_req_addr, 0);
        chk({p, "_cdb_req"}, bus.cdb_req, 0);
        chk({p, "_cdb_id"}, bus.cdb_id_out, 0);
        chk({p, "_cdb_data"}, bus.cdb_data_out, 0);
        chk({p, "_free_flag"}, bus.free_tag_flag, 0);
        chk({p, "_free_tag"}, bus.free_this_tag, 0);
        chk({p, "_busy"}, bus.busy, 0);
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_done", done_cnt, target);
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        int cnt;
        int run;
        int max_run;
        int free_base;
        logic [3:0] seen_q;
        logic       activity;

        for (int s = 0; s < 3; s++) begin
            st_arm[s] = 0; st_done[s] = 0; st_drop[s] = 0;
            st_op[s] = '0; st_off[s] = '0;
        end
        aff_force_low = 1'b0;
        req_stall = 0; resp_lat = 0; grant_stall = 0;
        ovr_en = 1'b0; ovr_data = '0;

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("por");
        rst = 1'b0;

        // Reset during MEM_WAIT; the late response must be ignored
        st_op[0] = 64'h2000; st_off[0] = 64'h8; resp_lat = 30;
        push(4'd6, 64'h2008);
        st_arm[0]++;
        n = 0;
        while (!bus.mem_req_valid && n < 50) begin @(negedge clk); n++; end
        while (bus.mem_req_valid && n < 50) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        chk("busy_in_mem_wait", bus.busy, 1);
        #2;
        rst = 1'b1;
        st_drop[0]++;
        #1;
        check_zero("async_rst");
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (!bus.mem_resp_valid && n < 60) begin @(negedge clk); n++; end
        chk("late_resp_seen", bus.mem_resp_valid, 1);
        repeat (3) begin
            @(negedge clk);
            chk("late_resp_no_cdb", bus.cdb_req, 0);
            chk("late_resp_idle", bus.busy, 0);
        end

        // Slot 1, 0x1000 + 0x20, data 0xDEADBEEF after 3 cycles
        resp_lat = 3; ovr_en = 1'b1; ovr_data = 64'h0000_0000_DEAD_BEEF;
        st_op[1] = 64'h1000; st_off[1] = 64'h20;
        push(4'd7, 64'h1020);
        st_arm[1]++;
        n = 0;
        while (bus.query_tag == 4'd0 && n < 20) begin @(negedge clk); n++; end
        chk("query_tag_slot1", bus.query_tag, 7);
        wait_done(1, 100);
        ovr_en = 1'b0; resp_lat = 0;

        // All slots ready from rr_ptr=0: order 6,7,8,6
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        st_op[0] = 64'h100; st_off[0] = 64'h1;
        st_op[1] = 64'h200; st_off[1] = 64'h2;
        st_op[2] = 64'h300; st_off[2] = 64'h3;
        push(4'd6, 64'h101);
        push(4'd7, 64'h202);
        push(4'd8, 64'h303);
        push(4'd6, 64'h101);
        st_arm[0] += 2; st_arm[1]++; st_arm[2]++;
        wait_done(5, 200);
        chk("rr_sb_drained", sb.size(), 0);

        // Wrapping address and minimum IDLE-to-IDLE latency
        st_op[2] = 64'hFFFF_FFFF_FFFF_FFF0; st_off[2] = 64'h20;
        push(4'd8, 64'h10);
        st_arm[2]++;
        n = 0;
        while (!bus.busy && n < 20) begin @(negedge clk); n++; end
        cnt = 0;
        while (bus.busy && cnt < 40) begin @(negedge clk); cnt++; end
        chk("busy_cycles_min", cnt, 5);
        wait_done(6, 50);

        // Memory stall 4 cycles, grant stall 5 cycles, single free pulse
        req_stall = 4; grant_stall = 5;
        st_op[0] = 64'h4000; st_off[0] = 64'h40;
        push(4'd6, 64'h4040);
        free_base = free_cnt;
        st_arm[0]++;
        wait_done(7, 100);
        repeat (3) @(negedge clk);
        chk("free_pulse_count", free_cnt - free_base, 1);
        req_stall = 0; grant_stall = 0;

        // Station reports not-ready during AGEN: load dropped, no side effects
        aff_force_low = 1'b1;
        st_op[1] = 64'h5000; st_off[1] = 64'h0;
        st_arm[1]++;
        seen_q = 4'd0; activity = 1'b0; run = 0; max_run = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.query_tag != 4'd0) seen_q = bus.query_tag;
            if (bus.mem_req_valid || bus.cdb_req || bus.free_tag_flag) activity = 1'b1;
            run = bus.busy ? run + 1 : 0;
            if (run > max_run) max_run = run;
        end
        chk("agen_fail_query", seen_q, 7);
        chk("agen_fail_activity", activity, 0);
        chk("agen_fail_busy_run", max_run, 1);
        st_drop[1]++;
        aff_force_low = 1'b0;
        repeat (3) @(negedge clk);
        chk("agen_fail_idle", bus.busy, 0);
        chk("agen_fail_query_zero", bus.query_tag, 0);
        chk("final_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_exec_unit.md
Name: load_exec_unit

Overview:
- Downstream consumer of the 3-entry load reservation station (tags ld_1=6, ld_2=7, ld_3=8).
- Picks one operand-ready load entry and computes its effective address (op + offset), writing it back to the station.
- Performs the memory read, broadcasts the loaded value on the CDB under its station tag, then pulses the free request that releases the station entry.
- Services one load at a time.

Parameters:
XLEN, 64, operand/address/data width
LD_TAG_BASE, 6, tag of station slot 0; slots 1 and 2 are LD_TAG_BASE+1 and LD_TAG_BASE+2

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
ready_bus  in  3  station ready flags; bit2=slot0, bit1=slot1, bit0=slot2
ld_aff_ready  in  1  station query response: queried entry ready
ld_affinity_op  in  XLEN  queried entry base operand
ld_affinity_offset  in  XLEN  queried entry offset
query_tag  out  4  tag being queried (0 = none)
address  out  XLEN  computed effective address, written back to station
mem_req_valid  out  1  memory read request
mem_req_addr  out  XLEN  read address
mem_req_ready  in  1  memory accepts request
mem_resp_valid  in  1  read data valid
mem_resp_data  in  XLEN  read data
cdb_req  out  1  request CDB slot
cdb_grant  in  1  CDB arbiter grant
cdb_id_out  out  4  broadcast tag
cdb_data_out  out  XLEN  broadcast value
free_tag_flag  out  1  one-cycle free pulse to station
free_this_tag  out  4  tag to free
busy  out  1  a load is in flight (state != IDLE)

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, rr_ptr=0.
  - All outputs 0: query_tag, address, mem_req_valid, mem_req_addr, cdb_req, cdb_id_out, cdb_data_out, free_tag_flag, free_this_tag, busy.
  - Any in-flight load is abandoned. Late mem_resp_valid is ignored until the next MEM_WAIT.
- Outputs are registered except busy, which is decoded from state.
- Slot select in IDLE: round-robin over ready slots, starting at rr_ptr. rr_ptr = selected slot + 1, mod 3. No ready slot: stay in IDLE.
- States:
  - IDLE
    - On select: latch slot and tag = LD_TAG_BASE + slot.
    - Drive query_tag=tag; go to AGEN.
  - AGEN (1 cycle)
    - If ld_aff_ready=1: eff = ld_affinity_op + ld_affinity_offset, mod 2^XLEN, carry dropped.
    - Drive address=eff, latch eff internally, go to MEM_REQ.
    - If ld_aff_ready=0: query_tag<=0, go to IDLE; no memory, CDB or free activity.
  - MEM_REQ
    - query_tag=0, mem_req_valid=1, mem_req_addr=eff.
    - Held stable until mem_req_ready=1, then go to MEM_WAIT.
    - Accept takes one cycle when mem_req_ready is already high.
  - MEM_WAIT
    - Wait any number of cycles for mem_resp_valid.
    - On response: latch data, cdb_req=1, cdb_id_out=tag, cdb_data_out=data; go to CDB.
    - mem_resp_valid seen in the same cycle the request is accepted is ignored (minimum latency 1).
  - CDB
    - Hold cdb_req/cdb_id_out/cdb_data_out stable until cdb_grant=1.
    - On grant: cdb_req=0, free_tag_flag=1, free_this_tag=tag; go to FREE.
  - FREE (1 cycle)
    - free_tag_flag=0; go to IDLE.
    - The station clears the entry on this edge, so a stale ready bit for the freed slot is never reselected.
- cdb_id_out and free_this_tag return to 0 when deasserted.
- ready_bus changes after selection do not abort the load.
- Minimum IDLE-to-IDLE latency with zero-wait memory and immediate grant: 6 cycles.

Decomposition:
- Shared package holds:
  - tag constants: notag=0, add_1..add_3=1..3, mult_1/2=4/5, ld_1..ld_3=6..8, st_1/2=9/10
  - state encoding: IDLE, AGEN, MEM_REQ, MEM_WAIT, CDB, FREE
  - XLEN
- One natural sub-module: ld_rr_picker, a 3-way round-robin selector with inputs ready vector and rr_ptr, outputs grant one-hot and valid.

Test Plan:
- Reset mid-MEM_WAIT, then release → all outputs 0, busy=0. A later mem_resp_valid produces no cdb_req.
- Slot1 ready; op=0x1000, offset=0x20; memory returns 0xDEADBEEF after 3 cycles; grant immediate →
  - query_tag=7
  - address=mem_req_addr=0x1020
  - cdb_id_out=7, cdb_data_out=0xDEADBEEF
  - free_tag_flag pulses 1 cycle with free_this_tag=7
- All three slots continuously ready → service order tags 6, 7, 8, 6; never the same slot twice in a row.
- op=0xFFFF_FFFF_FFFF_FFF0, offset=0x20 → address=0x10 (wrap, carry dropped).
- mem_req_ready low for 4 cycles, then cdb_grant low for 5 cycles → mem_req_addr and cdb_data_out stable throughout. Exactly one free pulse.
- AGEN with ld_aff_ready=0 → returns to IDLE. mem_req_valid, cdb_req and free_tag_flag stay 0.
